// File: rtl/phy_clock_switch_ctrl.sv
// Glitch-safe clock source sequencer for phy_clock_mux: gate off, wait, change
// select, settle, gate back on. Sole writer of the mux select.
module phy_clock_switch_ctrl #(
    parameter int NUM_CLOCKS      = 4,
    parameter int NUM_CLOCK_SEL   = 2,
    parameter int RESET_SEL       = 0,
    parameter int GATE_OFF_CYCLES = 8,
    parameter int SETTLE_CYCLES   = 8,
    parameter int CNT_W           = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [NUM_CLOCK_SEL-1:0] req_sel,
    output logic                     req_ready,
    output logic [NUM_CLOCK_SEL-1:0] clk_sel,
    output logic                     clk_gate_en,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OFF = 2'd1,
        WAIT_ON  = 2'd2
    } state_t;

    localparam logic [NUM_CLOCK_SEL-1:0] RESET_SEL_W  = NUM_CLOCK_SEL'(RESET_SEL);
    localparam logic [NUM_CLOCK_SEL:0]   NUM_CLOCKS_W = (NUM_CLOCK_SEL + 1)'(NUM_CLOCKS);
    localparam logic [CNT_W-1:0]         GATE_OFF_LD  = CNT_W'(GATE_OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0]         SETTLE_LD    = CNT_W'(SETTLE_CYCLES - 1);

    state_t                   state_reg, state_next;
    logic [CNT_W-1:0]         cnt_reg, cnt_next;
    logic [NUM_CLOCK_SEL-1:0] target_reg, target_next;
    logic [NUM_CLOCK_SEL-1:0] sel_reg, sel_next;
    logic                     gate_reg, gate_next;
    logic                     done_reg, done_next;
    logic                     err_reg, err_next;
    logic                     sel_invalid;

    // Extra bit so NUM_CLOCKS == 2**NUM_CLOCK_SEL still compares correctly.
    assign sel_invalid = ({1'b0, req_sel} >= NUM_CLOCKS_W);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        target_next = target_reg;
        sel_next    = sel_reg;
        gate_next   = gate_reg;
        done_next   = 1'b0;
        err_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (sel_invalid) begin
                        err_next = 1'b1;
                    end else if (req_sel == sel_reg) begin
                        done_next = 1'b1;
                    end else begin
                        target_next = req_sel;
                        gate_next   = 1'b0;
                        cnt_next    = GATE_OFF_LD;
                        state_next  = WAIT_OFF;
                    end
                end
            end
            WAIT_OFF: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    sel_next   = target_reg;
                    cnt_next   = SETTLE_LD;
                    state_next = WAIT_ON;
                end
            end
            WAIT_ON: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    gate_next  = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            target_reg <= RESET_SEL_W;
            sel_reg    <= RESET_SEL_W;
            gate_reg   <= 1'b1;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            target_reg <= target_next;
            sel_reg    <= sel_next;
            gate_reg   <= gate_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    assign req_ready   = (state_reg == IDLE);
    assign busy        = (state_reg != IDLE);
    assign clk_sel     = sel_reg;
    assign clk_gate_en = gate_reg;
    assign done        = done_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_phy_clock_switch_ctrl.sv
// Self-checking bench for phy_clock_switch_ctrl: directed scenarios plus random
// traffic against a timeline model (acceptance edge + fixed offsets).
module tb_phy_clock_switch_ctrl;

    localparam int NC = 4;
    localparam int SW = 3;
    localparam int G  = 8;
    localparam int S  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic [SW-1:0] req_sel = '0;
    logic          req_ready;
    logic [SW-1:0] clk_sel;
    logic          clk_gate_en;
    logic          busy;
    logic          done;
    logic          err;

    phy_clock_switch_ctrl #(
        .NUM_CLOCKS     (NC),
        .NUM_CLOCK_SEL  (SW),
        .RESET_SEL      (0),
        .GATE_OFF_CYCLES(G),
        .SETTLE_CYCLES  (S),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_ready  (req_ready),
        .clk_sel    (clk_sel),
        .clk_gate_en(clk_gate_en),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Timeline model: a switch is just "accepted at cycle A"; outputs follow from A.
    logic [SW-1:0] m_sel, m_target;
    logic          m_gate, m_done, m_err, m_active;
    int            m_acc_cyc;
    int            cyc = 0;
    logic          accepted;
    logic          edge_rst;
    logic          mon_en = 1'b0;

    task automatic step();
        @(posedge clk);
        cyc++;
        edge_rst = reset;
        accepted = 1'b0;
        if (reset) begin
            m_sel = '0; m_gate = 1'b1; m_done = 1'b0; m_err = 1'b0; m_active = 1'b0;
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (m_active) begin
                if (cyc - m_acc_cyc == G) m_sel = m_target;
                if (cyc - m_acc_cyc == G + S) begin
                    m_gate = 1'b1; m_done = 1'b1; m_active = 1'b0;
                end
            end else if (req_valid) begin
                accepted = 1'b1;
                if (int'(req_sel) >= NC) m_err = 1'b1;
                else if (req_sel == m_sel) m_done = 1'b1;
                else begin
                    m_active = 1'b1; m_target = req_sel; m_acc_cyc = cyc; m_gate = 1'b0;
                end
            end
        end
        #1;
    endtask

    // Ordering monitor: the select may only move while the gate is off on both sides.
    logic [SW-1:0] prev_sel;
    logic          prev_gate;
    always @(negedge clk) begin
        if (mon_en && !edge_rst && clk_sel !== prev_sel) begin
            checks++;
            if (prev_gate !== 1'b0 || clk_gate_en !== 1'b0)
                $display("FAIL sel_while_gated cyc=%0d sel %0d->%0d gate_before=%b gate_after=%b required gate 0",
                         cyc, prev_sel, clk_sel, prev_gate, clk_gate_en);
            else passes++;
        end
        prev_sel  <= clk_sel;
        prev_gate <= clk_gate_en;
    end

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b1; req_sel = 3'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({clk_sel, clk_gate_en, busy, req_ready, done, err} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0})
                $display("FAIL reset_defaults got sel=%0d gate=%b busy=%b ready=%b done=%b err=%b required 0,1,0,1,0,0",
                         clk_sel, clk_gate_en, busy, req_ready, done, err);
            else passes++;
        end
        req_valid = 1'b0; reset = 1'b0;
        step();
        checks++;
        if ({clk_sel, clk_gate_en, busy, req_ready} !== {m_sel, m_gate, m_active, !m_active})
            $display("FAIL reset_release got sel=%0d gate=%b busy=%b required sel=%0d gate=%b busy=%b",
                     clk_sel, clk_gate_en, busy, m_sel, m_gate, m_active);
        else passes++;
        mon_en = 1'b1;
    endtask

    task automatic test_noop();
        req_valid = 1'b1; req_sel = 3'd0;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({clk_sel, clk_gate_en, busy, req_ready, done, err} !== {m_sel, m_gate, m_active, !m_active, m_done, m_err}
                || clk_gate_en !== 1'b1 || busy !== 1'b0)
                $display("FAIL noop i=%0d got sel=%0d gate=%b busy=%b done=%b required sel=%0d gate=1 busy=0 done=%b",
                         i, clk_sel, clk_gate_en, busy, done, m_sel, m_done);
            else passes++;
            step();
        end
    endtask

    task automatic test_err();
        req_valid = 1'b1; req_sel = 3'd5;
        step();
        req_valid = 1'b0;
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || clk_sel !== 3'd0 || clk_gate_en !== 1'b1 || busy !== 1'b0)
            $display("FAIL err_pulse got err=%b done=%b sel=%0d gate=%b busy=%b required 1,0,0,1,0",
                     err, done, clk_sel, clk_gate_en, busy);
        else passes++;
        step();
        checks++;
        if (err !== m_err || busy !== 1'b0)
            $display("FAIL err_one_cycle got err=%b busy=%b required err=%b busy=0", err, busy, m_err);
        else passes++;
    endtask

    task automatic test_switch();
        int gate_low = 0;
        int sel_at   = -1;
        int done_at  = -1;
        req_valid = 1'b1; req_sel = 3'd2;
        step();
        req_valid = 1'b0; req_sel = 3'd1;   // later changes must not redirect the switch
        for (int i = 0; i <= G + S + 2; i++) begin
            checks++;
            if ({clk_sel, clk_gate_en, busy, req_ready, done, err} !== {m_sel, m_gate, m_active, !m_active, m_done, m_err})
                $display("FAIL switch E%0d got sel=%0d gate=%b busy=%b ready=%b done=%b required sel=%0d gate=%b busy=%b done=%b",
                         i, clk_sel, clk_gate_en, busy, req_ready, done, m_sel, m_gate, m_active, m_done);
            else passes++;
            if (clk_gate_en === 1'b0) gate_low++;
            if (clk_sel === 3'd2 && sel_at < 0) sel_at = i;
            if (done === 1'b1 && done_at < 0) done_at = i;
            step();
        end
        checks++;
        if (gate_low != G + S || sel_at != G || done_at != G + S)
            $display("FAIL switch_timing got gate_low=%0d sel_at=E%0d done_at=E%0d required %0d,E%0d,E%0d",
                     gate_low, sel_at, done_at, G + S, G, G + S);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int   gate_high = 0;
        int   phase     = 0;
        logic done_prev;
        reset = 1'b1; step(); reset = 1'b0;
        req_valid = 1'b1; req_sel = 3'd1;
        step();
        req_sel = 3'd3;
        for (int i = 0; i < 2 * (G + S) + 6 && phase < 2; i++) begin
            done_prev = done;
            step();
            checks++;
            if ({clk_sel, clk_gate_en, busy, done} !== {m_sel, m_gate, m_active, m_done})
                $display("FAIL b2b i=%0d got sel=%0d gate=%b busy=%b done=%b required sel=%0d gate=%b busy=%b done=%b",
                         i, clk_sel, clk_gate_en, busy, done, m_sel, m_gate, m_active, m_done);
            else passes++;
            if (phase == 0 && clk_gate_en === 1'b1) phase = 1;
            if (phase == 1) begin
                if (clk_gate_en === 1'b1) gate_high++;
                else begin
                    phase = 2;
                    checks++;
                    if (done_prev !== 1'b1 || gate_high != 1)
                        $display("FAIL b2b_accept got done_prev=%b gate_high=%0d required done_prev=1 gate_high=1",
                                 done_prev, gate_high);
                    else passes++;
                end
            end
        end
        checks++;
        if (phase != 2)
            $display("FAIL b2b_timeout got phase=%0d required 2", phase);
        else passes++;
        req_valid = 1'b0;
        for (int i = 0; i < G + S + 2; i++) step();
        checks++;
        if (clk_sel !== 3'd3 || clk_gate_en !== 1'b1 || busy !== 1'b0)
            $display("FAIL b2b_final got sel=%0d gate=%b busy=%b required 3,1,0", clk_sel, clk_gate_en, busy);
        else passes++;
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; step(); reset = 1'b0;
        req_valid = 1'b1; req_sel = 3'd2;
        step();                              // E0
        req_valid = 1'b0;
        for (int i = 1; i < 5; i++) step();  // E1..E4
        reset = 1'b1;
        step();                              // E5 with reset
        reset = 1'b0;
        checks++;
        if ({clk_sel, clk_gate_en, busy, done, err} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_mid got sel=%0d gate=%b busy=%b done=%b err=%b required 0,1,0,0,0",
                     clk_sel, clk_gate_en, busy, done, err);
        else passes++;
        for (int i = 0; i < G + S; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || clk_sel !== 3'd0 || clk_gate_en !== 1'b1 || busy !== m_active)
                $display("FAIL reset_mid_after i=%0d got done=%b sel=%0d gate=%b busy=%b required 0,0,1,%b",
                         i, done, clk_sel, clk_gate_en, busy, m_active);
            else passes++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            req_valid = ($urandom_range(0, 2) != 0);
            req_sel   = SW'($urandom_range(0, 7));
            reset     = ($urandom_range(0, 99) == 0);
            step();
            checks++;
            if ({clk_sel, clk_gate_en, busy, req_ready, done, err} !== {m_sel, m_gate, m_active, !m_active, m_done, m_err})
                $display("FAIL random cyc=%0d got sel=%0d gate=%b busy=%b ready=%b done=%b err=%b required sel=%0d gate=%b busy=%b done=%b err=%b",
                         cyc, clk_sel, clk_gate_en, busy, req_ready, done, err, m_sel, m_gate, m_active, m_done, m_err);
            else passes++;
        end
        reset = 1'b0; req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_noop();
        test_err();
        test_switch();
        test_back_to_back();
        test_reset_mid();
        test_random();
        step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
